// File: rtl/rl_coeff_lut_bank.sv
// Runtime-loadable coefficient LUT bank: NUM_TABLES RAMs filled over a valid/ready stream,
// then read all orders at once for one {segment, bin} address with a fixed 2-cycle latency.
module rl_coeff_lut_bank #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_TABLES  = 2,
    parameter int unsigned SEGMENT_NUM = 14,
    parameter int unsigned SEG_WIDTH   = 4,
    parameter int unsigned BIN_WIDTH   = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_load_start,
    input  logic [DATA_WIDTH-1:0]            i_load_data,
    input  logic                             i_load_valid,
    output logic                             o_load_ready,
    output logic                             o_tables_valid,
    input  logic                             i_rd_valid,
    input  logic [SEG_WIDTH-1:0]             i_rd_segment,
    input  logic [BIN_WIDTH-1:0]             i_rd_bin,
    output logic                             o_rd_ready,
    output logic                             o_out_valid,
    output logic [NUM_TABLES*DATA_WIDTH-1:0] o_out_coeff,
    output logic                             o_out_oob
);

    localparam int unsigned BIN_NUM   = 2 ** BIN_WIDTH;
    localparam int unsigned DEPTH     = SEGMENT_NUM * BIN_NUM;
    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned TW        = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1;
    localparam int unsigned OUT_WIDTH = NUM_TABLES * DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_READY
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_load_ready_nxt;

    logic [AW-1:0]          r_wr_ptr;
    logic [TW-1:0]          r_wr_tbl;
    logic                   w_wr_fire;
    logic                   w_wr_last;

    logic                   w_rd_fire;
    logic                   w_rd_oob;
    logic                   r_s1_valid;
    logic                   r_s1_oob;
    logic [AW-1:0]          r_s1_addr;
    logic                   r_s2_valid;
    logic                   r_s2_oob;
    logic [OUT_WIDTH-1:0]   w_ram_cat;

    assign w_rd_fire = i_rd_valid && o_rd_ready;
    assign w_rd_oob  = (32'(i_rd_segment) >= SEGMENT_NUM);
    assign w_wr_fire = rst_n && (r_state == S_LOAD) && i_load_valid && o_load_ready && !i_load_start;
    assign w_wr_last = (r_wr_ptr == AW'(DEPTH - 1)) && (r_wr_tbl == TW'(NUM_TABLES - 1));

    // Next state; load_ready is only granted once no lookup can still be in the RAM stage.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_ready_nxt = 1'b0;
        case (r_state)
            S_IDLE:  if (i_load_start) w_state_nxt = S_LOAD;
            S_LOAD: begin
                if (i_load_start)               w_state_nxt = S_LOAD;
                else if (w_wr_fire && w_wr_last) w_state_nxt = S_READY;
            end
            S_READY: if (i_load_start) w_state_nxt = S_LOAD;
            default: w_state_nxt = S_IDLE;
        endcase
        w_load_ready_nxt = (w_state_nxt == S_LOAD) && !r_s1_valid && !w_rd_fire;
    end

    // Control, write pointer and lookup pipeline registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            o_load_ready   <= 1'b0;
            o_tables_valid <= 1'b0;
            o_rd_ready     <= 1'b0;
            o_out_valid    <= 1'b0;
            o_out_coeff    <= '0;
            o_out_oob      <= 1'b0;
            r_wr_ptr       <= '0;
            r_wr_tbl       <= '0;
            r_s1_valid     <= 1'b0;
            r_s1_oob       <= 1'b0;
            r_s1_addr      <= '0;
            r_s2_valid     <= 1'b0;
            r_s2_oob       <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            o_load_ready   <= w_load_ready_nxt;
            o_tables_valid <= (w_state_nxt == S_READY);
            o_rd_ready     <= (w_state_nxt == S_READY);

            if (i_load_start) begin
                r_wr_ptr <= '0;
                r_wr_tbl <= '0;
            end else if (w_wr_fire) begin
                if (r_wr_ptr == AW'(DEPTH - 1)) begin
                    r_wr_ptr <= '0;
                    r_wr_tbl <= r_wr_tbl + TW'(1);
                end else begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
            end

            r_s1_valid <= w_rd_fire;
            if (w_rd_fire) begin
                r_s1_oob  <= w_rd_oob;
                r_s1_addr <= AW'({i_rd_segment, i_rd_bin});
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) r_s2_oob <= r_s1_oob;

            o_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                o_out_coeff <= r_s2_oob ? '0 : w_ram_cat;
                o_out_oob   <= r_s2_oob;
            end
        end
    end

    // One simple dual-port RAM per coefficient order; out-of-range segments skip the read.
    for (genvar k = 0; k < NUM_TABLES; k++) begin : g_tbl
        logic [DATA_WIDTH-1:0] r_mem [DEPTH];
        logic [DATA_WIDTH-1:0] r_q;

        always_ff @(posedge clk) begin
            if (w_wr_fire && (r_wr_tbl == TW'(k))) r_mem[r_wr_ptr] <= i_load_data;
            if (r_s1_valid && !r_s1_oob)          r_q <= r_mem[r_s1_addr];
        end

        assign w_ram_cat[k*DATA_WIDTH +: DATA_WIDTH] = r_q;
    end

endmodule

// File: tb/tb_rl_coeff_lut_bank.sv
// Scoreboard bench for rl_coeff_lut_bank with a tiny 2-table, 2-segment, 4-bin configuration.
module tb_rl_coeff_lut_bank;

    localparam int unsigned DW    = 32;
    localparam int unsigned NT    = 2;
    localparam int unsigned SN    = 2;
    localparam int unsigned SW    = 2;
    localparam int unsigned BW    = 2;
    localparam int unsigned DEPTH = SN * (2 ** BW);
    localparam int unsigned OW    = NT * DW;

    logic          clk;
    logic          rst_n;
    logic          load_start;
    logic [DW-1:0] load_data;
    logic          load_valid;
    logic          load_ready;
    logic          tables_valid;
    logic          rd_valid;
    logic [SW-1:0] rd_segment;
    logic [BW-1:0] rd_bin;
    logic          rd_ready;
    logic          out_valid;
    logic [OW-1:0] out_coeff;
    logic          out_oob;

    rl_coeff_lut_bank #(
        .DATA_WIDTH (DW),
        .NUM_TABLES (NT),
        .SEGMENT_NUM(SN),
        .SEG_WIDTH  (SW),
        .BIN_WIDTH  (BW)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_load_start  (load_start),
        .i_load_data   (load_data),
        .i_load_valid  (load_valid),
        .o_load_ready  (load_ready),
        .o_tables_valid(tables_valid),
        .i_rd_valid    (rd_valid),
        .i_rd_segment  (rd_segment),
        .i_rd_bin      (rd_bin),
        .o_rd_ready    (rd_ready),
        .o_out_valid   (out_valid),
        .o_out_coeff   (out_coeff),
        .o_out_oob     (out_oob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          oob;
        logic [OW-1:0] coeff;
        int            stamp;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] mdl [NT*DEPTH];
    int            mdl_ptr  = 0;
    int            cyc      = 0;
    int            n_cmp    = 0;
    int            n_bad    = 0;
    int            run_len  = 0;
    int            best_run = 0;

    task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: tracks accepted load words and predicts each accepted lookup.
    exp_t push_e;
    int   push_idx;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (rd_valid && rd_ready) begin
                push_e.stamp = cyc + 1;
                push_e.oob   = (int'(rd_segment) >= int'(SN));
                push_idx     = int'(rd_segment) * (2 ** BW) + int'(rd_bin);
                if (push_e.oob) push_e.coeff = '0;
                else            push_e.coeff = {mdl[DEPTH + push_idx], mdl[push_idx]};
                sb.push_back(push_e);
            end
            if (load_start) begin
                mdl_ptr = 0;
            end else if (load_valid && load_ready) begin
                mdl[mdl_ptr] = load_data;
                mdl_ptr++;
            end
        end
    end

    exp_t pop_e;
    always @(negedge clk) begin
        if (out_valid) begin
            run_len++;
            if (run_len > best_run) best_run = run_len;
            if (sb.size() == 0) begin
                chk("unexpected_out", 64'(sb.size()), 64'd1);
            end else begin
                pop_e = sb.pop_front();
                chk("coeff", out_coeff, pop_e.coeff);
                chk("oob", 64'(out_oob), 64'(pop_e.oob));
                chk("latency", 64'(cyc - pop_e.stamp), 64'd2);
            end
        end else begin
            run_len = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_words(input int base, input bit pulse, input int n_words, output int cycles);
        int k;
        bit acc;
        k      = 0;
        cycles = 0;
        if (pulse) begin
            load_start = 1'b1;
            tick();
            load_start = 1'b0;
        end
        while (k < n_words && cycles < 200) begin
            load_valid = 1'b1;
            load_data  = DW'(base + k);
            if (k == int'(NT * DEPTH) - 1) chk("tv_before_last", 64'(tables_valid), 64'd0);
            @(posedge clk);
            acc = load_ready;
            #1;
            cycles++;
            if (acc) k++;
        end
        load_valid = 1'b0;
        if (k < n_words) chk("load_timeout", 64'(k), 64'(n_words));
    endtask

    task automatic rd(input int seg, input int bin);
        rd_valid   = 1'b1;
        rd_segment = SW'(seg);
        rd_bin     = BW'(bin);
        tick();
        rd_valid   = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 20) begin
            tick();
            n++;
        end
        tick();
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int ncyc;
    initial begin
        rst_n      = 1'b0;
        load_start = 1'b0;
        load_data  = '0;
        load_valid = 1'b0;
        rd_valid   = 1'b0;
        rd_segment = '0;
        rd_bin     = '0;
        repeat (3) tick();
        chk("reset_flags", 64'({load_ready, tables_valid, rd_ready, out_valid, out_oob}), 64'd0);
        chk("reset_coeff", out_coeff, 64'd0);

        // IDLE ignores lookups and offers no load slot.
        rst_n    = 1'b1;
        rd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle_quiet", 64'({rd_ready, out_valid, tables_valid, load_ready}), 64'd0);
        end
        rd_valid = 1'b0;

        // First load, back-to-back words k=0..15.
        load_words(0, 1'b1, 16, ncyc);
        chk("load_cycles", 64'(ncyc), 64'd16);
        chk("tv_rise", 64'(tables_valid), 64'd1);
        chk("rd_ready_up", 64'(rd_ready), 64'd1);
        rd(1, 2);
        drain();
        chk("seg1_bin2", out_coeff, {32'd14, 32'd6});

        // All addresses back-to-back, no bubbles.
        best_run = 0;
        for (int a = 0; a < 8; a++) rd(a / 4, a % 4);
        drain();
        chk("no_bubbles", 64'(best_run), 64'd8);

        // Out-of-range segment between valid neighbours.
        rd(0, 1);
        rd(3, 0);
        rd(1, 3);
        drain();
        chk("oob_neighbour", out_coeff, {32'd15, 32'd7});

        // Reload requested in the same cycle as an accepted lookup.
        rd_valid   = 1'b1;
        rd_segment = '0;
        rd_bin     = '0;
        load_start = 1'b1;
        tick();
        rd_valid   = 1'b0;
        load_start = 1'b0;
        chk("lr_after_start", 64'(load_ready), 64'd0);
        chk("rr_after_start", 64'(rd_ready), 64'd0);
        tick();
        chk("lr_inflight", 64'(load_ready), 64'd0);
        chk("tv_fall", 64'(tables_valid), 64'd0);
        load_words(100, 1'b0, 16, ncyc);
        chk("tv_reload", 64'(tables_valid), 64'd1);
        rd(0, 0);
        drain();
        chk("reload_00", out_coeff, {32'd108, 32'd100});

        // Reset in the middle of a load.
        load_words(200, 1'b1, 6, ncyc);
        rst_n = 1'b0;
        tick();
        chk("midload_flags", 64'({load_ready, tables_valid, rd_ready, out_valid, out_oob}), 64'd0);
        chk("midload_coeff", out_coeff, 64'd0);
        rst_n      = 1'b1;
        load_valid = 1'b1;
        tick();
        tick();
        chk("idle_no_lr", 64'({load_ready, tables_valid}), 64'd0);
        load_valid = 1'b0;

        // Fresh complete load after the aborted one.
        load_words(50, 1'b1, 16, ncyc);
        chk("fresh_cycles", 64'(ncyc), 64'd16);
        for (int a = 0; a < 8; a++) rd(a / 4, a % 4);
        drain();
        chk("fresh_last", out_coeff, {32'd65, 32'd57});

        // A lookup in flight at reset never produces output.
        rd(1, 1);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_discard", 64'(out_valid), 64'd0);
        end

        repeat (2) tick();
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rl_coeff_lut_bank.md
# rl_coeff_lut_bank

Parametrised, runtime-loadable coefficient memory for the range-limited force interpolation pipeline. It holds NUM_TABLES coefficient tables (c0..c(NUM_TABLES-1)) for the segment/bin interpolation scheme and returns all orders for one {segment, bin} lookup in a single access. Tables are streamed in after reset through a valid/ready load port, so coefficients no longer come from init files. It sits between the r² segment/bin decoder and the polynomial evaluator of each force pipeline.

## Interface
- DATA_WIDTH, 32, coefficient word width (single float)
- NUM_TABLES, 2, number of coefficient tables (interpolation order + 1)
- SEGMENT_NUM, 14, segments per table
- SEG_WIDTH, 4, segment index width; SEGMENT_NUM ≤ 2^SEG_WIDTH
- BIN_WIDTH, 8, bin index width; BIN_NUM = 2^BIN_WIDTH (derived)
- DEPTH (localparam), SEGMENT_NUM·BIN_NUM words per table
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- load_start  in  1  single-cycle request to (re)load all tables
- load_data  in  DATA_WIDTH  coefficient word
- load_valid  in  1  load_data valid
- load_ready  out  1  load word accepted when load_valid & load_ready
- tables_valid  out  1  level; all tables fully loaded
- rd_valid  in  1  lookup request
- rd_segment  in  SEG_WIDTH  segment index
- rd_bin  in  BIN_WIDTH  bin index
- rd_ready  out  1  lookup accepted when rd_valid & rd_ready
- out_valid  out  1  out_coeff valid (one-cycle pulse per lookup)
- out_coeff  out  NUM_TABLES·DATA_WIDTH  table k at bits [k·DATA_WIDTH +: DATA_WIDTH]
- out_oob  out  1  lookup segment ≥ SEGMENT_NUM

## Operation
- Storage: NUM_TABLES inferred RAMs, DEPTH × DATA_WIDTH, registered address and registered output; address = {rd_segment, rd_bin}.
- States: IDLE (after reset), LOAD, READY.
- IDLE: rd_ready=0, load_ready=0; load_start → LOAD.
- LOAD: on entry wr_ptr=0, wr_tbl=0, tables_valid=0. load_ready=1 only when no lookup is in flight (pipeline empty). Each accepted word writes table[wr_tbl][wr_ptr]; wr_ptr increments; at DEPTH-1 it wraps to 0 and wr_tbl increments. Acceptance of the word at (NUM_TABLES-1, DEPTH-1) → READY, tables_valid=1 next cycle.
- load_start while in LOAD restarts at wr_ptr=0, wr_tbl=0; a load word in the same cycle is dropped.
- READY: rd_ready=1; load_start → LOAD (rd_ready low from next cycle; a lookup accepted in the load_start cycle completes with old contents).
- Lookup: out_coeff returns every table at the address; if rd_segment ≥ SEGMENT_NUM, out_coeff=0 and out_oob=1 (memory not read).
- Write-load order: table-major, then segment, then bin.
- Reset (any state, including mid-load): state=IDLE; all outputs 0; in-flight lookups discarded (out_valid never asserts for them). RAM contents not cleared.

## Timing
- Reset values: load_ready=0, tables_valid=0, rd_ready=0, out_valid=0, out_coeff=0, out_oob=0.
- Lookup latency 2: request accepted at edge t → out_valid, out_coeff, out_oob registered at edge t+2.
- Throughput: one lookup per cycle in READY, no bubbles.
- out_coeff holds its last value when out_valid=0.
- Load throughput one word per cycle; first word accepted no earlier than the cycle after load_start and two cycles after the last accepted lookup.
- tables_valid rises the cycle after the final word; falls the cycle after load_start.

## Test plan
Bench parameters: NUM_TABLES=2, SEGMENT_NUM=2, BIN_WIDTH=2 (DEPTH=8, 16 load words).
- Reset, then hold rd_valid=1 → rd_ready, out_valid, tables_valid stay 0; load_ready stays 0 until load_start.
- load_start, stream words k=0..15 (value k) back-to-back → tables_valid=1 one cycle after word 15; lookup (seg 1, bin 2) → out_valid 2 cycles later, table0=6, table1=14, out_oob=0.
- 8 back-to-back lookups covering all addresses → 8 consecutive out_valid cycles, data in request order, zero bubbles.
- Lookup with rd_segment=3 → out_oob=1, out_coeff=0 at latency 2; neighbouring valid lookups unaffected.
- load_start in the same cycle as an accepted lookup → old data returned at latency 2; load_ready not asserted before that lookup retires; reload with values k+100 → (0,0) returns 100 and 108.
- Assert rst_n=0 after word 5 of a load → all outputs 0 next cycle; state IDLE; a fresh complete load then yields correct data.
